// File: rtl/dual_issue_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : dual_issue_regfile
//  Purpose  : Register file with two write ports and RD_PORTS independent
//             combinational read ports. Entry 0 is hard-wired to zero.
//             After reset, a clear sequence zeroes every entry, one per
//             clock, before the file accepts writes or returns data.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W    register width in bits                        (default 32)
//    ADDR_W    address width, depth = 2**ADDR_W              (default 5)
//    RD_PORTS  number of independent read ports, 1..8        (default 4)
//
//  Ports
//    clk        in   1                  clock, rising-edge active
//    rst        in   1                  asynchronous reset, active low
//    w0_en      in   1                  write port 0 enable
//    w0_addr    in   ADDR_W             write port 0 address
//    w0_data    in   DATA_W             write port 0 data
//    w1_en      in   1                  write port 1 enable (wins ties)
//    w1_addr    in   ADDR_W             write port 1 address
//    w1_data    in   DATA_W             write port 1 data
//    rd_addr    in   RD_PORTS*ADDR_W    packed read addresses, port k at
//                                       [k*ADDR_W +: ADDR_W]
//    rd_data    out  RD_PORTS*DATA_W    packed read data, port k at
//                                       [k*DATA_W +: DATA_W]
//    init_done  out  1                  high once the clear sequence is done
//
//  Build option
//    REGFILE_BYPASS_EN  when defined, a read that hits an accepted write in
//                       the same cycle returns the write data immediately
//                       (port 1 over port 0). Undefined: reads return the
//                       stored value only, so writes show up one cycle later.
// ============================================================================
module dual_issue_regfile #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int RD_PORTS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         w0_en,
   input  logic [ADDR_W-1:0]            w0_addr,
   input  logic [DATA_W-1:0]            w0_data,
   input  logic                         w1_en,
   input  logic [ADDR_W-1:0]            w1_addr,
   input  logic [DATA_W-1:0]            w1_data,
   input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
   output logic [RD_PORTS*DATA_W-1:0]   rd_data,
   output logic                         init_done
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int                c_DEPTH = 1 << ADDR_W;
   // The counter carries one spare bit so the terminal value 2**ADDR_W-1
   // can be compared, and then incremented past, without wrapping to zero.
   localparam logic [ADDR_W:0]   c_LAST  = (ADDR_W+1)'(c_DEPTH - 1);
   localparam logic [ADDR_W:0]   c_ONE   = (ADDR_W+1)'(1);

   // ------------------------------------------------------------------------
   // Clear sequencer state
   // ------------------------------------------------------------------------
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W:0]     r_cnt;
   logic [ADDR_W:0]     w_cnt_nxt;

   // Storage; deliberately has no reset, it is zeroed by the clear sequence.
   logic [DATA_W-1:0]   r_mem [c_DEPTH];

   logic                w_ready;
   logic                w_we0;
   logic                w_we1;

   // ------------------------------------------------------------------------
   // Sequencer state register. Reset drops the file back into CLEAR with the
   // counter at entry 0 immediately, without waiting for a clock edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer next-state logic. In CLEAR the counter walks every entry
   // once; the edge that clears the last entry is also the edge that moves
   // to READY, so the whole sweep takes exactly c_DEPTH edges.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_CLEAR: begin
            w_cnt_nxt = r_cnt + c_ONE;
            if (r_cnt == c_LAST) begin
               w_state_nxt = ST_READY;
            end
         end
         ST_READY: begin
            // Terminal state; only reset leaves it.
            w_state_nxt = ST_READY;
         end
         default: begin
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_ready   = (r_state == ST_READY);
   assign init_done = w_ready;

   // ------------------------------------------------------------------------
   // Accepted writes: only once ready, and never to entry 0.
   // ------------------------------------------------------------------------
   assign w_we0 = w0_en && w_ready && (w0_addr != '0);
   assign w_we1 = w1_en && w_ready && (w1_addr != '0);

   // ------------------------------------------------------------------------
   // Storage update. During CLEAR the sweep owns the array and user writes
   // are ignored. In READY both ports write in the same edge; port 1 is
   // issued last so it wins when both target the same entry.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
         r_mem[r_cnt[ADDR_W-1:0]] <= '0;
      end else begin
         if (w_we0) begin
            r_mem[w0_addr] <= w0_data;
         end
         if (w_we1) begin
            r_mem[w1_addr] <= w1_data;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read ports: each one is a separate combinational mux, so any number of
   // ports may look at the same entry at once. Output is forced to zero
   // while not ready (this also covers reset, which forces CLEAR at once)
   // and for entry 0.
   // ------------------------------------------------------------------------
   for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_val;

      assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         w_val = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
         // Forward same-cycle writes; port 1 is checked last so it wins.
         // The accept terms already exclude entry 0 and the CLEAR state.
         if (w_we0 && (w0_addr == w_addr)) begin
            w_val = w0_data;
         end
         if (w_we1 && (w1_addr == w_addr)) begin
            w_val = w1_data;
         end
`endif
         if (!w_ready || (w_addr == '0)) begin
            w_val = '0;
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = w_val;
   end

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dual_issue_regfile
//  Purpose  : Self-checking bench for dual_issue_regfile. A driver applies
//             directed and random cycles and pushes expected read data into
//             a scoreboard queue; a monitor on the falling edge pops and
//             compares. Expected values come from a behavioural model: an
//             array of entries plus a count of clock edges since reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dual_issue_regfile;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int RD_PORTS = 4;
   localparam int DEPTH    = 1 << ADDR_W;

   logic                         clk = 1'b0;
   logic                         rst = 1'b0;
   logic                         w0_en = 1'b0;
   logic [ADDR_W-1:0]            w0_addr = '0;
   logic [DATA_W-1:0]            w0_data = '0;
   logic                         w1_en = 1'b0;
   logic [ADDR_W-1:0]            w1_addr = '0;
   logic [DATA_W-1:0]            w1_data = '0;
   logic [RD_PORTS*ADDR_W-1:0]   rd_addr = '0;
   logic [RD_PORTS*DATA_W-1:0]   rd_data;
   logic                         init_done;

   dual_issue_regfile #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .RD_PORTS (RD_PORTS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .w0_en     (w0_en),
      .w0_addr   (w0_addr),
      .w0_data   (w0_data),
      .w1_en     (w1_en),
      .w1_addr   (w1_addr),
      .w1_data   (w1_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------------
   typedef struct {
      string                        name;
      logic [RD_PORTS*DATA_W-1:0]   data;
      logic                         done;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // ------------------------------------------------------------------------
   // Reference model: entry contents and number of edges seen with reset
   // released. The file is usable once DEPTH such edges have occurred.
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] m_mem [DEPTH];
   int                m_edges = 0;

   function automatic logic m_ready();
      return (rst == 1'b1) && (m_edges >= DEPTH);
   endfunction

   function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      if (!m_ready() || a == '0) return '0;
      v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
      if (w0_en && w0_addr == a) v = w0_data;
      if (w1_en && w1_addr == a) v = w1_data;
`endif
      return v;
   endfunction

   task automatic model_reset();
      m_edges = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
   endtask

   // Effect of one rising edge with the currently driven inputs.
   task automatic model_edge();
      if (!rst) begin
         m_edges = 0;
      end else if (m_edges >= DEPTH) begin
         if (w0_en && w0_addr != '0) m_mem[w0_addr] = w0_data;
         if (w1_en && w1_addr != '0) m_mem[w1_addr] = w1_data;
      end else begin
         m_edges++;
      end
   endtask

   task automatic push_expect(input string name);
      exp_t e;
      e.name = name;
      e.done = m_ready();
      e.data = '0;
      for (int k = 0; k < RD_PORTS; k++)
         e.data[k*DATA_W +: DATA_W] = model_read(rd_addr[k*ADDR_W +: ADDR_W]);
      sb_q.push_back(e);
   endtask

   // ------------------------------------------------------------------------
   // Monitor: compares on the falling edge, away from the active edge.
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         checks++;
         if (rd_data !== mon_e.data) begin
            errors++;
            $display("FAIL %s rd_data got %h want %h", mon_e.name, rd_data, mon_e.data);
         end
         checks++;
         if (init_done !== mon_e.done) begin
            errors++;
            $display("FAIL %s init_done got %b want %b", mon_e.name, init_done, mon_e.done);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Driver helpers (called just after a rising edge)
   // ------------------------------------------------------------------------
   task automatic set_wr(input logic e0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input logic e1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
      w0_en = e0; w0_addr = a0; w0_data = d0;
      w1_en = e1; w1_addr = a1; w1_data = d1;
   endtask

   task automatic no_wr();
      set_wr(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic set_rd_all(input logic [ADDR_W-1:0] a);
      for (int k = 0; k < RD_PORTS; k++) rd_addr[k*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic set_rd_rand();
      for (int k = 0; k < RD_PORTS; k++)
         rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH-1));
   endtask

   task automatic cycle(input string name);
      push_expect(name);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Drop reset between edges and check that outputs clear before any edge.
   task automatic async_reset(input string name);
      #2 rst = 1'b0;
      model_reset();
      #1;
      push_expect(name);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic run_clear(input string name);
      rst = 1'b1;
      no_wr();
      for (int i = 0; i < DEPTH; i++) begin
         set_rd_rand();
         cycle(name);
      end
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      model_reset();
      @(posedge clk);
      #1;

      // Held in reset: everything reads zero, not done.
      set_rd_rand();
      cycle("reset_hold");
      set_wr(1'b1, 5'd4, 32'hCAFE0004, 1'b1, 5'd6, 32'hCAFE0006);
      set_rd_all(5'd4);
      cycle("reset_hold_wr");

      // Clear sweep; writes issued at clear cycle 10 must be ignored.
      rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 10) set_wr(1'b1, 5'd9, 32'h12345678, 1'b1, 5'd12, 32'h87654321);
         else         no_wr();
         set_rd_rand();
         cycle("clear_sweep");
      end
      no_wr();

      // Every address reads zero on every port.
      for (int a = 0; a < DEPTH; a += RD_PORTS) begin
         for (int k = 0; k < RD_PORTS; k++) rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a + k);
         cycle("post_clear_zero");
      end

      // Single write then broadcast read.
      set_wr(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0);
      set_rd_all(5'd3);
      cycle("wr3_same_cycle");
      no_wr();
      cycle("wr3_read");

      // Same-address double write: port 1 wins.
      set_wr(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222);
      set_rd_all(5'd7);
      cycle("wr7_dual_same_cycle");
      no_wr();
      cycle("wr7_dual_read");

      // Different addresses in one cycle: both land.
      set_wr(1'b1, 5'd10, 32'hAAAA0010, 1'b1, 5'd11, 32'hBBBB0011);
      rd_addr = {5'd11, 5'd10, 5'd11, 5'd10};
      cycle("dual_diff_same_cycle");
      no_wr();
      cycle("dual_diff_read");

      // Writes to entry 0 are discarded; entry 9 from the clear-time write is 0.
      set_wr(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
      set_rd_all(5'd0);
      cycle("wr0_same_cycle");
      no_wr();
      rd_addr = {5'd12, 5'd9, 5'd0, 5'd0};
      cycle("wr0_and_clear_wr_read");

      // Write-while-read on entry 5: old value first (no bypass) or new (bypass).
      set_wr(1'b1, 5'd5, 32'h0BADF00D, 1'b0, '0, '0);
      set_rd_all(5'd5);
      cycle("wr5_old");
      set_wr(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, '0, '0);
      cycle("wr5_bypass_cycle");
      no_wr();
      cycle("wr5_next_cycle");
      // Double match on entry 5 in the write cycle.
      set_wr(1'b1, 5'd5, 32'h01010101, 1'b1, 5'd5, 32'h02020202);
      cycle("wr5_dual_cycle");
      no_wr();
      cycle("wr5_dual_next");

      // Reset while READY: drops immediately, full sweep again, data gone.
      rd_addr = {5'd7, 5'd5, 5'd3, 5'd10};
      async_reset("reset_in_ready");
      cycle("reset_in_ready_hold");
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         set_rd_rand();
         cycle("clear_partial");
      end
      rd_addr = {5'd7, 5'd5, 5'd3, 5'd10};
      async_reset("reset_mid_clear");
      cycle("reset_mid_clear_hold");
      run_clear("clear_after_reset");
      rd_addr = {5'd7, 5'd5, 5'd3, 5'd10};
      cycle("data_lost_after_reset");
      rd_addr = {5'd11, 5'd12, 5'd9, 5'd1};
      cycle("data_lost_after_reset2");

      // Randomized traffic in READY, addresses biased toward collisions.
      for (int n = 0; n < 400; n++) begin
         w0_en   = 1'($urandom_range(0, 1));
         w1_en   = 1'($urandom_range(0, 1));
         w0_addr = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 7))
                                               : ADDR_W'($urandom_range(0, DEPTH-1));
         w1_addr = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 7))
                                               : ADDR_W'($urandom_range(0, DEPTH-1));
         w0_data = $urandom;
         w1_data = $urandom;
         for (int k = 0; k < RD_PORTS; k++)
            rd_addr[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 7))
                                                                      : ADDR_W'($urandom_range(0, DEPTH-1));
         cycle("random");
      end
      no_wr();

      // Let the monitor consume the last entry before reporting.
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
